lcd_frame_sequencer: RTL and testbench
======================================

// Module: lcd_frame_sequencer
// PURPOSE
//  Sequences the 8080-style 8-bit LCD write bus for the Julia-set display path.
//  Drives the rs/cs/wr/db inputs of the LCD write stage and produces every bus byte:
//  panel reset, init command list, window setup, then a full frame of RGB565 pixels
//  taken from the renderer over a valid/ready stream. Sits between renderer and LCD write stage.
// PARAMETERS
//  H_RES          320  pixels per line; column window end = H_RES-1
//  V_RES          240  lines per frame; page window end = V_RES-1
//  WR_LOW_CYCLES  2    clk cycles wr is held low per byte (>=1)
//  RESET_WAIT     1024 clk cycles for panel reset low time and for post-reset wait
//  INIT_LEN       16   entries in the init ROM
// PORTS
//  clk             in   1   system clock
//  in_reset        in   1   synchronous, active-high reset
//  in_start        in   1   pulse: start one frame (ignored while out_busy=1)
//  in_pix_valid    in   1   renderer pixel valid
//  in_pix_data     in   16  RGB565 pixel
//  out_pix_ready   out  1   pixel accepted on valid&ready
//  out_busy        out  1   1 during reset/init/frame; 0 only in IDLE
//  out_frame_done  out  1   one-cycle pulse after last pixel byte
//  out_lcd_rst_n   out  1   panel hardware reset, active low
//  out_rs          out  1   0=command byte, 1=data byte
//  out_cs          out  1   chip select, active low
//  out_wr          out  1   write strobe, active low; panel latches on rising edge
//  out_db          out  16  bus data; [15:8] always 8'h00
// BEHAVIOUR
//  Reset (any cycle, incl. mid-frame): next edge out_cs=1, out_wr=1, out_rs=1, out_db=0,
//   out_pix_ready=0, out_busy=1, out_frame_done=0, out_lcd_rst_n=0; FSM -> RST_LOW; counters cleared.
//  Byte engine: one byte = SETUP (1 cyc, wr=1, rs/db valid) + LOW (WR_LOW_CYCLES, wr=0)
//   + HOLD (1 cyc, wr=1). rs/db stable across all WR_LOW_CYCLES+2 cycles. Next byte may follow back-to-back.
//  FSM:
//   RST_LOW  : lcd_rst_n=0 for RESET_WAIT cycles -> RST_WAIT
//   RST_WAIT : lcd_rst_n=1, cs=1 for RESET_WAIT cycles -> INIT
//   INIT     : send ROM entries 0..INIT_LEN-1; entry {rs,byte}; cs low throughout -> IDLE
//   IDLE     : cs=1, busy=0; in_start -> WIN (start same cycle as leaving INIT is not possible)
//   WIN      : 11 bytes: 2A(c) 00 00 hi(H-1) lo(H-1), 2B(c) 00 00 hi(V-1) lo(V-1), 2C(c); (c)=rs 0
//   PIX_REQ  : ready=1 while byte engine idle; on valid&ready latch pixel, ready=0 -> PIX_HI
//   PIX_HI   : send pixel[15:8], rs=1 -> PIX_LO
//   PIX_LO   : send pixel[7:0], rs=1; pixel_count+1; count==H_RES*V_RES -> DONE else PIX_REQ
//   DONE     : frame_done=1 one cycle, cs=1 -> IDLE
//  Backpressure: valid low in PIX_REQ holds state, wr=1, cs stays low, count preserved.
//  Pixel counter width = $clog2(H_RES*V_RES+1); no wrap within a frame; cleared on WIN entry.
//  in_start during busy dropped (not queued). in_pix_valid outside PIX_REQ ignored.
//  Window values are 16-bit; hi/lo split of H_RES-1, V_RES-1 exact.
// STRUCTURE
//  lcd_pkg: CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C, state enum,
//   init entry typedef {logic rs; logic [7:0] b}.
//  Sub-module lcd_init_rom: combinational index -> init entry, INIT_LEN entries.
//  Byte engine is an internal phase counter, not a separate module.
// TESTING (H_RES=4, V_RES=2, WR_LOW_CYCLES=2, RESET_WAIT=8, INIT_LEN=2)
//  Release reset -> lcd_rst_n low 8 cyc, high; 8 cyc later first ROM byte; busy=0 after 2 bytes.
//  Any byte -> exactly 4 cycles, wr low exactly 2, rs/db constant, db[15:8]=0.
//  in_start in IDLE -> bytes 2A,00,00,00,03,2B,00,00,00,01,2C; rs=0 only on 2A/2B/2C.
//  Pixel 16'hF81F -> db 16'h00F8 then 16'h001F, rs=1; after 8th pixel frame_done 1 cyc, busy=0.
//  valid low 10 cycles mid-frame -> no wr pulses, ready stays 1; resume continues at next pixel.
//  in_reset mid-PIX_HI -> next cycle cs=1, wr=1, ready=0, lcd_rst_n=0; in_start while busy ignored.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, FSM states and byte-entry type for the LCD frame sequencer.
// The window-setup byte table lives here so that the top and the ROM use one byte format.
package lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;
    localparam int         WIN_LEN   = 11;

    typedef enum logic [3:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_WIN,
        ST_PIX_REQ,
        ST_PIX_HI,
        ST_PIX_LO,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] b;
    } init_entry_t;

    // Column window is sent first, then the page window, then RAMWR opens the pixel stream.
    function automatic init_entry_t win_byte(input logic [3:0]  idx,
                                             input logic [15:0] col_end,
                                             input logic [15:0] page_end);
        init_entry_t e;
        e = '{rs: 1'b1, b: 8'h00};
        case (idx)
            4'd0:    e = '{rs: 1'b0, b: CMD_CASET};
            4'd3:    e.b = col_end[15:8];
            4'd4:    e.b = col_end[7:0];
            4'd5:    e = '{rs: 1'b0, b: CMD_PASET};
            4'd8:    e.b = page_end[15:8];
            4'd9:    e.b = page_end[7:0];
            4'd10:   e = '{rs: 1'b0, b: CMD_RAMWR};
            default: e = '{rs: 1'b1, b: 8'h00};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Panel power-up command list: combinational lookup from index to {rs, byte}.
// Indices at or beyond INIT_LEN read back as a harmless NOP command.
module lcd_init_rom
    import lcd_pkg::*;
#(
    parameter int INIT_LEN = 16
) (
    input  logic [7:0]  index,
    output init_entry_t entry
);

    always_comb begin
        entry = '{rs: 1'b0, b: 8'h00};
        if (int'(index) < INIT_LEN) begin
            case (index)
                8'd0:    entry = '{rs: 1'b0, b: 8'h11};
                8'd1:    entry = '{rs: 1'b0, b: 8'h3A};
                8'd2:    entry = '{rs: 1'b1, b: 8'h55};
                8'd3:    entry = '{rs: 1'b0, b: 8'h36};
                8'd4:    entry = '{rs: 1'b1, b: 8'h28};
                8'd5:    entry = '{rs: 1'b0, b: 8'hB1};
                8'd6:    entry = '{rs: 1'b1, b: 8'h00};
                8'd7:    entry = '{rs: 1'b1, b: 8'h1B};
                8'd8:    entry = '{rs: 1'b0, b: 8'hB6};
                8'd9:    entry = '{rs: 1'b1, b: 8'h0A};
                8'd10:   entry = '{rs: 1'b1, b: 8'h82};
                8'd11:   entry = '{rs: 1'b0, b: 8'h26};
                8'd12:   entry = '{rs: 1'b1, b: 8'h01};
                8'd13:   entry = '{rs: 1'b0, b: 8'h13};
                8'd14:   entry = '{rs: 1'b0, b: 8'h20};
                8'd15:   entry = '{rs: 1'b0, b: 8'h29};
                default: entry = '{rs: 1'b0, b: 8'h00};
            endcase
        end
    end

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Drives the 8080-style LCD write bus: panel reset, init list, window setup, then one
// RGB565 frame from the renderer. A phase counter shapes every byte into setup/low/hold.
module lcd_frame_sequencer
    import lcd_pkg::*;
#(
    parameter int H_RES         = 320,
    parameter int V_RES         = 240,
    parameter int WR_LOW_CYCLES = 2,
    parameter int RESET_WAIT    = 1024,
    parameter int INIT_LEN      = 16
) (
    input  logic        clk,
    input  logic        in_reset,
    input  logic        in_start,
    input  logic        in_pix_valid,
    input  logic [15:0] in_pix_data,
    output logic        out_pix_ready,
    output logic        out_busy,
    output logic        out_frame_done,
    output logic        out_lcd_rst_n,
    output logic        out_rs,
    output logic        out_cs,
    output logic        out_wr,
    output logic [15:0] out_db
);

    localparam int TOTAL  = H_RES * V_RES;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int WAIT_W = $clog2(RESET_WAIT + 1);
    localparam int PH_W   = $clog2(WR_LOW_CYCLES + 2);
    localparam int IDX_W  = $clog2(INIT_LEN + 1);

    localparam logic [PH_W-1:0]   PH_RISE   = PH_W'(WR_LOW_CYCLES);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(WR_LOW_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RESET_WAIT - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TOTAL - 1);
    localparam logic [15:0]       COL_END   = 16'(H_RES - 1);
    localparam logic [15:0]       PAGE_END  = 16'(V_RES - 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [IDX_W-1:0]  init_idx;
    logic [3:0]        win_idx;
    logic [CNT_W-1:0]  pix_count;
    logic [15:0]       pix_buf;
    logic              byte_busy;
    logic [PH_W-1:0]   phase;
    logic              byte_done;
    logic [7:0]        db_byte;
    init_entry_t       rom_entry;
    init_entry_t       win_entry;

    // byte_done marks the hold cycle, so the next byte may be loaded on that same edge
    assign byte_done = byte_busy && (phase == PH_LAST);
    assign out_db    = {8'h00, db_byte};
    assign win_entry = win_byte(win_idx, COL_END, PAGE_END);

    lcd_init_rom #(.INIT_LEN(INIT_LEN)) u_init_rom (
        .index (8'(init_idx)),
        .entry (rom_entry)
    );

    task automatic load_byte(input logic rs, input logic [7:0] b);
        out_rs    <= rs;
        db_byte   <= b;
        out_wr    <= 1'b1;
        byte_busy <= 1'b1;
        phase     <= '0;
    endtask

    always_ff @(posedge clk) begin
        if (in_reset) begin
            state          <= ST_RST_LOW;
            wait_cnt       <= '0;
            init_idx       <= '0;
            win_idx        <= '0;
            pix_count      <= '0;
            pix_buf        <= '0;
            byte_busy      <= 1'b0;
            phase          <= '0;
            db_byte        <= 8'h00;
            out_cs         <= 1'b1;
            out_wr         <= 1'b1;
            out_rs         <= 1'b1;
            out_pix_ready  <= 1'b0;
            out_busy       <= 1'b1;
            out_frame_done <= 1'b0;
            out_lcd_rst_n  <= 1'b0;
        end else begin
            out_frame_done <= 1'b0;

            if (byte_busy) begin
                if (phase == PH_LAST) begin
                    byte_busy <= 1'b0;
                end else begin
                    phase  <= phase + 1'b1;
                    out_wr <= (phase == PH_RISE);
                end
            end

            case (state)
                ST_RST_LOW: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt      <= '0;
                        out_lcd_rst_n <= 1'b1;
                        state         <= ST_RST_WAIT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                // The first ROM byte goes out on the edge that ends the post-reset wait
                ST_RST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        out_cs   <= 1'b0;
                        load_byte(rom_entry.rs, rom_entry.b);
                        init_idx <= IDX_W'(1);
                        state    <= ST_INIT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_INIT: begin
                    if (byte_done) begin
                        if (init_idx == IDX_W'(INIT_LEN)) begin
                            out_cs   <= 1'b1;
                            out_busy <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            load_byte(rom_entry.rs, rom_entry.b);
                            init_idx <= init_idx + 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (in_start) begin
                        out_busy  <= 1'b1;
                        out_cs    <= 1'b0;
                        win_idx   <= '0;
                        pix_count <= '0;
                        state     <= ST_WIN;
                    end
                end
                ST_WIN: begin
                    if (!byte_busy || byte_done) begin
                        if (win_idx == 4'(WIN_LEN)) begin
                            out_pix_ready <= 1'b1;
                            state         <= ST_PIX_REQ;
                        end else begin
                            load_byte(win_entry.rs, win_entry.b);
                            win_idx <= win_idx + 1'b1;
                        end
                    end
                end
                ST_PIX_REQ: begin
                    if (in_pix_valid && out_pix_ready) begin
                        pix_buf       <= in_pix_data;
                        out_pix_ready <= 1'b0;
                        state         <= ST_PIX_HI;
                    end
                end
                ST_PIX_HI: begin
                    if (!byte_busy) begin
                        load_byte(1'b1, pix_buf[15:8]);
                    end else if (byte_done) begin
                        load_byte(1'b1, pix_buf[7:0]);
                        state <= ST_PIX_LO;
                    end
                end
                ST_PIX_LO: begin
                    if (byte_done) begin
                        pix_count <= pix_count + 1'b1;
                        if (pix_count == CNT_LAST) begin
                            out_frame_done <= 1'b1;
                            out_cs         <= 1'b1;
                            state          <= ST_DONE;
                        end else begin
                            out_pix_ready <= 1'b1;
                            state         <= ST_PIX_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    out_busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_RST_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Directed bench for lcd_frame_sequencer on a 4x2 panel; a negedge monitor records each
// write strobe as {rs, db, low length, start cycle, stability} for the scenario tasks.
module tb_lcd_frame_sequencer;

    logic        clk;
    logic        in_reset;
    logic        in_start;
    logic        in_pix_valid;
    logic [15:0] in_pix_data;
    logic        out_pix_ready;
    logic        out_busy;
    logic        out_frame_done;
    logic        out_lcd_rst_n;
    logic        out_rs;
    logic        out_cs;
    logic        out_wr;
    logic [15:0] out_db;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rs;
        logic [15:0] db;
        int          low_len;
        int          fall;
        logic        stable;
        logic        cs_low;
    } rec_t;

    rec_t recs[$];

    logic [7:0]  win_exp_b  [0:10] = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h03,
                                       8'h2B, 8'h00, 8'h00, 8'h00, 8'h01, 8'h2C};
    logic        win_exp_rs [0:10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                       1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] pix_vec    [0:7]  = '{16'hF81F, 16'h07E0, 16'h001F, 16'h1234,
                                       16'hABCD, 16'h0000, 16'hFFFF, 16'h8001};

    lcd_frame_sequencer #(
        .H_RES(4), .V_RES(2), .WR_LOW_CYCLES(2), .RESET_WAIT(8), .INIT_LEN(2)
    ) dut (
        .clk            (clk),
        .in_reset       (in_reset),
        .in_start       (in_start),
        .in_pix_valid   (in_pix_valid),
        .in_pix_data    (in_pix_data),
        .out_pix_ready  (out_pix_ready),
        .out_busy       (out_busy),
        .out_frame_done (out_frame_done),
        .out_lcd_rst_n  (out_lcd_rst_n),
        .out_rs         (out_rs),
        .out_cs         (out_cs),
        .out_wr         (out_wr),
        .out_db         (out_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          mon_cyc = 0;
    logic        mon_low = 1'b0;
    logic        prev_wr = 1'b1;
    logic [16:0] prev_bus = '0;
    logic [16:0] cap;
    int          low_len;
    int          fall_cyc;
    logic        stab;
    logic        cs_ok;

    always @(negedge clk) begin
        mon_cyc++;
        if (in_reset) begin
            mon_low = 1'b0;
        end else if (!out_wr && !mon_low) begin
            mon_low  = 1'b1;
            low_len  = 1;
            cap      = {out_rs, out_db};
            stab     = prev_wr && (prev_bus == cap);
            cs_ok    = !out_cs;
            fall_cyc = mon_cyc;
        end else if (!out_wr) begin
            low_len++;
            if ({out_rs, out_db} != cap) stab = 1'b0;
            if (out_cs) cs_ok = 1'b0;
        end else if (mon_low) begin
            mon_low = 1'b0;
            if ({out_rs, out_db} != cap) stab = 1'b0;
            recs.push_back('{rs: cap[16], db: cap[15:0], low_len: low_len,
                             fall: fall_cyc, stable: stab, cs_low: cs_ok});
        end
        prev_wr  = out_wr;
        prev_bus = {out_rs, out_db};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        in_reset     = 1'b1;
        in_start     = 1'b0;
        in_pix_valid = 1'b0;
        in_pix_data  = 16'h0000;
        tick();
        tick();
        n_checks++;
        if ({out_cs, out_wr, out_rs, out_pix_ready, out_busy, out_frame_done, out_lcd_rst_n} !== 7'b1110100) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b expected %b",
                     {out_cs, out_wr, out_rs, out_pix_ready, out_busy, out_frame_done, out_lcd_rst_n}, 7'b1110100);
        end
        n_checks++;
        if (out_db !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL reset_db: got %h expected %h", out_db, 16'h0000);
        end
        in_reset = 1'b0;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (out_lcd_rst_n) break;
        end
        n_checks++;
        if (n !== 8) begin
            n_fail++;
            $display("[TB] FAIL rst_low_len: got %0d expected %0d", n, 8);
        end
    endtask

    task automatic test_init();
        int m;
        int k;
        recs.delete();
        m = 0;
        while (m < 40) begin
            tick();
            m++;
            if (!out_cs) break;
        end
        n_checks++;
        if (m !== 8) begin
            n_fail++;
            $display("[TB] FAIL rst_wait_len: got %0d expected %0d", m, 8);
        end
        n_checks++;
        if ({out_rs, out_wr, out_db} !== {1'b0, 1'b1, 16'h0011}) begin
            n_fail++;
            $display("[TB] FAIL init_first_byte: got %h expected %h", {out_rs, out_wr, out_db}, {1'b0, 1'b1, 16'h0011});
        end
        k = 0;
        while (out_busy && k < 60) begin
            tick();
            k++;
        end
        n_checks++;
        if (k !== 8) begin
            n_fail++;
            $display("[TB] FAIL init_duration: got %0d expected %0d", k, 8);
        end
        n_checks++;
        if (recs.size() !== 2) begin
            n_fail++;
            $display("[TB] FAIL init_count: got %0d expected %0d", recs.size(), 2);
        end else begin
            n_checks++;
            if ({recs[0].rs, recs[0].db, recs[1].rs, recs[1].db} !== {1'b0, 16'h0011, 1'b0, 16'h003A}) begin
                n_fail++;
                $display("[TB] FAIL init_bytes: got %h expected %h",
                         {recs[0].rs, recs[0].db, recs[1].rs, recs[1].db}, {1'b0, 16'h0011, 1'b0, 16'h003A});
            end
            n_checks++;
            if (recs[1].fall - recs[0].fall !== 4) begin
                n_fail++;
                $display("[TB] FAIL init_spacing: got %0d expected %0d", recs[1].fall - recs[0].fall, 4);
            end
        end
        n_checks++;
        if ({out_cs, out_wr, out_pix_ready} !== 3'b110) begin
            n_fail++;
            $display("[TB] FAIL idle_bus: got %b expected %b", {out_cs, out_wr, out_pix_ready}, 3'b110);
        end
    endtask

    task automatic test_window();
        int t;
        recs.delete();
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        n_checks++;
        if (out_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL start_busy: got %b expected %b", out_busy, 1'b1);
        end
        t = 0;
        while (!out_pix_ready && t < 100) begin
            tick();
            t++;
        end
        n_checks++;
        if (!out_pix_ready) begin
            n_fail++;
            $display("[TB] FAIL window_ready_timeout: got %b expected %b", out_pix_ready, 1'b1);
        end
        n_checks++;
        if (recs.size() !== 11) begin
            n_fail++;
            $display("[TB] FAIL window_count: got %0d expected %0d", recs.size(), 11);
        end else begin
            for (int i = 0; i < 11; i++) begin
                n_checks++;
                if ({recs[i].rs, recs[i].db} !== {win_exp_rs[i], 8'h00, win_exp_b[i]}) begin
                    n_fail++;
                    $display("[TB] FAIL window_byte%0d: got %h expected %h", i,
                             {recs[i].rs, recs[i].db}, {win_exp_rs[i], 8'h00, win_exp_b[i]});
                end
                n_checks++;
                if ({recs[i].low_len, recs[i].stable, recs[i].cs_low} !== {32'd2, 1'b1, 1'b1}) begin
                    n_fail++;
                    $display("[TB] FAIL window_strobe%0d: got low=%0d stable=%b cs=%b expected low=2 stable=1 cs=1",
                             i, recs[i].low_len, recs[i].stable, recs[i].cs_low);
                end
                if (i > 0) begin
                    n_checks++;
                    if (recs[i].fall - recs[i-1].fall !== 4) begin
                        n_fail++;
                        $display("[TB] FAIL window_spacing%0d: got %0d expected %0d", i, recs[i].fall - recs[i-1].fall, 4);
                    end
                end
            end
        end
    endtask

    task automatic test_pixels();
        int t;
        int nrec;
        int fd;
        logic ready_drop;
        recs.delete();
        for (int p = 0; p < 8; p++) begin
            if (p == 3) begin
                in_pix_valid = 1'b0;
                t = 0;
                while (!out_pix_ready && t < 50) begin
                    tick();
                    t++;
                end
                nrec = recs.size();
                ready_drop = 1'b0;
                repeat (10) begin
                    tick();
                    if (!out_pix_ready || !out_wr || out_cs) ready_drop = 1'b1;
                end
                n_checks++;
                if ({ready_drop, 32'(recs.size())} !== {1'b0, 32'(nrec)}) begin
                    n_fail++;
                    $display("[TB] FAIL backpressure: got drop=%b bytes=%0d expected drop=0 bytes=%0d",
                             ready_drop, recs.size(), nrec);
                end
            end
            in_pix_valid = 1'b1;
            in_pix_data  = pix_vec[p];
            t = 0;
            while (!out_pix_ready && t < 50) begin
                tick();
                t++;
            end
            n_checks++;
            if (!out_pix_ready) begin
                n_fail++;
                $display("[TB] FAIL pix_ready_timeout%0d: got %b expected %b", p, out_pix_ready, 1'b1);
            end
            tick();
            in_pix_valid = 1'b0;
            in_pix_data  = 16'hDEAD;
        end
        fd = 0;
        t  = 0;
        while (out_busy && t < 100) begin
            tick();
            t++;
            if (out_frame_done) fd++;
        end
        n_checks++;
        if ({out_busy, 32'(fd)} !== {1'b0, 32'd1}) begin
            n_fail++;
            $display("[TB] FAIL frame_done: got busy=%b pulses=%0d expected busy=0 pulses=1", out_busy, fd);
        end
        n_checks++;
        if (recs.size() !== 16) begin
            n_fail++;
            $display("[TB] FAIL pixel_count: got %0d expected %0d", recs.size(), 16);
        end else begin
            for (int p = 0; p < 8; p++) begin
                n_checks++;
                if ({recs[2*p].rs, recs[2*p].db, recs[2*p+1].rs, recs[2*p+1].db} !==
                    {1'b1, 8'h00, pix_vec[p][15:8], 1'b1, 8'h00, pix_vec[p][7:0]}) begin
                    n_fail++;
                    $display("[TB] FAIL pixel%0d: got %h expected %h", p,
                             {recs[2*p].rs, recs[2*p].db, recs[2*p+1].rs, recs[2*p+1].db},
                             {1'b1, 8'h00, pix_vec[p][15:8], 1'b1, 8'h00, pix_vec[p][7:0]});
                end
                n_checks++;
                if ({recs[2*p].low_len, recs[2*p+1].low_len, recs[2*p].stable, recs[2*p+1].stable,
                     recs[2*p+1].fall - recs[2*p].fall} !== {32'd2, 32'd2, 1'b1, 1'b1, 32'd4}) begin
                    n_fail++;
                    $display("[TB] FAIL pixel_strobe%0d: got low=%0d/%0d stable=%b%b gap=%0d expected low=2/2 stable=11 gap=4",
                             p, recs[2*p].low_len, recs[2*p+1].low_len, recs[2*p].stable, recs[2*p+1].stable,
                             recs[2*p+1].fall - recs[2*p].fall);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        int nrec;
        logic woke;
        recs.delete();
        in_pix_valid = 1'b1;
        in_pix_data  = 16'hA55A;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        repeat (5) tick();
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        t = 0;
        while (out_busy && t < 400) begin
            tick();
            t++;
        end
        n_checks++;
        if (out_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_timeout: got busy=%b expected busy=0", out_busy);
        end
        n_checks++;
        if (recs.size() !== 27) begin
            n_fail++;
            $display("[TB] FAIL b2b_bytes: got %0d expected %0d", recs.size(), 27);
        end else begin
            n_checks++;
            if ({recs[11].db, recs[12].db, recs[26].db} !== {16'h00A5, 16'h005A, 16'h005A}) begin
                n_fail++;
                $display("[TB] FAIL b2b_pixel_bytes: got %h expected %h",
                         {recs[11].db, recs[12].db, recs[26].db}, {16'h00A5, 16'h005A, 16'h005A});
            end
        end
        nrec = recs.size();
        woke = 1'b0;
        repeat (20) begin
            tick();
            if (out_busy) woke = 1'b1;
        end
        n_checks++;
        if ({woke, 32'(recs.size())} !== {1'b0, 32'(nrec)}) begin
            n_fail++;
            $display("[TB] FAIL start_while_busy_dropped: got busy=%b bytes=%0d expected busy=0 bytes=%0d",
                     woke, recs.size(), nrec);
        end
        in_pix_valid = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int t;
        logic woke;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        t = 0;
        while (!out_pix_ready && t < 100) begin
            tick();
            t++;
        end
        in_pix_valid = 1'b1;
        in_pix_data  = 16'hF81F;
        tick();
        in_pix_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({out_wr, out_cs, out_rs, out_db} !== {1'b0, 1'b0, 1'b1, 16'h00F8}) begin
            n_fail++;
            $display("[TB] FAIL pix_hi_strobe: got %h expected %h", {out_wr, out_cs, out_rs, out_db}, {1'b0, 1'b0, 1'b1, 16'h00F8});
        end
        recs.delete();
        in_reset = 1'b1;
        in_start = 1'b1;
        tick();
        n_checks++;
        if ({out_cs, out_wr, out_pix_ready, out_lcd_rst_n, out_busy, out_frame_done} !== 6'b110010) begin
            n_fail++;
            $display("[TB] FAIL midframe_reset: got %b expected %b",
                     {out_cs, out_wr, out_pix_ready, out_lcd_rst_n, out_busy, out_frame_done}, 6'b110010);
        end
        in_reset = 1'b0;
        tick();
        in_start = 1'b0;
        t = 0;
        while (out_busy && t < 100) begin
            tick();
            t++;
        end
        woke = 1'b0;
        repeat (10) begin
            tick();
            if (out_busy) woke = 1'b1;
        end
        n_checks++;
        if ({woke, out_busy, 32'(recs.size())} !== {1'b0, 1'b0, 32'd2}) begin
            n_fail++;
            $display("[TB] FAIL reinit_after_reset: got woke=%b busy=%b bytes=%0d expected woke=0 busy=0 bytes=2",
                     woke, out_busy, recs.size());
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_window();
        test_pixels();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
